// File: rtl/cover_pkg.sv
// Shared constants and helpers for the toggle-coverage detector and its reporter.
package cover_pkg;

    localparam int COVER_WIDTH = 27;

    // Bits needed to hold a count from 0 up to w inclusive.
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < (64'(w) + 64'd1)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cover_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module cover_popcount
    import cover_pkg::*;
#(
    parameter int  WIDTH = COVER_WIDTH,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CW-1:0]    count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = bits;
        end else begin : g_split
            localparam int LO  = WIDTH / 2;
            localparam int HI  = WIDTH - LO;
            localparam int LCW = cnt_width(LO);
            localparam int HCW = cnt_width(HI);

            logic [LCW-1:0] lo_cnt_s;
            logic [HCW-1:0] hi_cnt_s;

            cover_popcount #(.WIDTH(LO)) u_lo (
                .bits  (bits[LO-1:0]),
                .count (lo_cnt_s)
            );

            cover_popcount #(.WIDTH(HI)) u_hi (
                .bits  (bits[WIDTH-1:LO]),
                .count (hi_cnt_s)
            );

            assign count = CW'(lo_cnt_s) + CW'(hi_cnt_s);
        end
    endgenerate

endmodule

// File: rtl/cover_toggle_detect.sv
// Per-bit toggle detector producing event pulses, a sticky coverage mask and its count.
module cover_toggle_detect
    import cover_pkg::*;
#(
    parameter int  WIDTH = COVER_WIDTH,
    parameter bit  ONCE  = 1'b1,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sig,
    input  logic             clr,
    output logic [WIDTH-1:0] valid,
    output logic [WIDTH-1:0] covered,
    output logic [CW-1:0]    cov_count,
    output logic             all_covered
);

    logic [WIDTH-1:0] prev_r;
    logic             armed_r;
    logic [WIDTH-1:0] toggle_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] covered_nxt_s;
    logic [CW-1:0]    count_nxt_s;

    // Toggle detection, report suppression mask and next coverage mask.
    always_comb begin
        toggle_s      = '0;
        mask_s        = '0;
        covered_nxt_s = covered;
        if (armed_r && en) begin
            toggle_s = sig ^ prev_r;
        end else begin
            toggle_s = '0;
        end
        // A clr cycle reports against an empty mask so simultaneous toggles are not lost.
        if (ONCE && !clr) begin
            mask_s = covered;
        end else begin
            mask_s = '0;
        end
        if (clr) begin
            covered_nxt_s = toggle_s;
        end else begin
            covered_nxt_s = covered | toggle_s;
        end
    end

    cover_popcount #(.WIDTH(WIDTH)) u_popcount (
        .bits  (covered_nxt_s),
        .count (count_nxt_s)
    );

    // Sample history, arming, and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r      <= '0;
            armed_r     <= 1'b0;
            valid       <= '0;
            covered     <= '0;
            cov_count   <= '0;
            all_covered <= 1'b0;
        end else begin
            if (en) begin
                prev_r <= sig;
            end else begin
                prev_r <= prev_r;
            end
            armed_r     <= en;
            valid       <= toggle_s & ~mask_s;
            covered     <= covered_nxt_s;
            cov_count   <= count_nxt_s;
            all_covered <= (count_nxt_s == CW'(WIDTH));
        end
    end

endmodule

// File: tb/tb_cover_toggle_detect.sv
// Self-checking bench: ONCE=1 and ONCE=0 instances against a per-bit behavioural model.
module tb_cover_toggle_detect;
    import cover_pkg::*;

    localparam int W  = 27;
    localparam int CW = cnt_width(W);
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic          clock;
    logic          reset;
    logic          en;
    logic          clr;
    logic [W-1:0]  sig;

    logic [W-1:0]  o_valid, o_cov, e_valid, e_cov;
    logic [CW-1:0] o_cnt, e_cnt;
    logic          o_all, e_all;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    cover_toggle_detect #(.WIDTH(W), .ONCE(1'b1)) u_once (
        .clock(clock), .reset(reset), .en(en), .sig(sig), .clr(clr),
        .valid(o_valid), .covered(o_cov), .cov_count(o_cnt), .all_covered(o_all)
    );

    cover_toggle_detect #(.WIDTH(W), .ONCE(1'b0)) u_every (
        .clock(clock), .reset(reset), .en(en), .sig(sig), .clr(clr),
        .valid(e_valid), .covered(e_cov), .cov_count(e_cnt), .all_covered(e_all)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 reports each bit once, index 1 reports every toggle.
    logic [W-1:0] m_valid [2];
    logic [W-1:0] m_cov   [2];
    int           m_cnt   [2];
    bit           m_all   [2];
    logic [W-1:0] m_prev;
    bit           m_armed;

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = '0;
                m_cov[k]   = '0;
                m_cnt[k]   = 0;
                m_all[k]   = 1'b0;
            end
            m_prev  = '0;
            m_armed = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < W; i++) begin
                    if (m_armed && en && (sig[i] != m_prev[i])) begin
                        m_valid[k][i] = clr || (k == 1) || !m_cov[k][i];
                        m_cov[k][i]   = 1'b1;
                    end else begin
                        m_valid[k][i] = 1'b0;
                        if (clr) m_cov[k][i] = 1'b0;
                    end
                end
                m_cnt[k] = $countones(m_cov[k]);
                m_all[k] = (m_cnt[k] == W);
            end
            if (en) m_prev = sig;
            m_armed = en;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            check("once.valid",   64'(o_valid), 64'(m_valid[0]));
            check("once.covered", 64'(o_cov),   64'(m_cov[0]));
            check("once.count",   64'(o_cnt),   64'(m_cnt[0]));
            check("once.all",     64'(o_all),   64'(m_all[0]));
            check("every.valid",  64'(e_valid), 64'(m_valid[1]));
            check("every.covered",64'(e_cov),   64'(m_cov[1]));
            check("every.count",  64'(e_cnt),   64'(m_cnt[1]));
            check("every.all",    64'(e_all),   64'(m_all[1]));
        end
    end

    task automatic tick(input logic r, input logic e, input logic c, input logic [W-1:0] s);
        reset = r;
        en    = e;
        clr   = c;
        sig   = s;
        @(negedge clock);
    endtask

    initial begin
        int p_once, p_every, run;
        logic [W-1:0] s, snap, flip;

        tick(1'b1, 1'b0, 1'b0, '0);
        chk_on = 1'b1;
        check("reset.covered", 64'(o_cov), 64'd0);
        check("reset.count",   64'(o_cnt), 64'd0);
        check("reset.all",     64'(o_all), 64'd0);
        check("reset.valid",   64'(o_valid), 64'd0);

        // Basic two-bit event after arming.
        tick(1'b0, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 27'h0000005);
        check("basic.valid",   64'(o_valid), 64'h5);
        check("basic.covered", 64'(o_cov),   64'h5);
        check("basic.count",   64'(o_cnt),   64'd2);
        tick(1'b0, 1'b1, 1'b0, 27'h0000005);
        check("basic.pulse_end", 64'(o_valid), 64'd0);

        // Repeated toggles of bit 0.
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        p_once = 0;
        p_every = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 27'h1 : 27'h0);
            if (o_valid[0]) p_once++;
            if (e_valid[0]) p_every++;
        end
        check("once.pulses",   64'(p_once),  64'd1);
        check("every.pulses",  64'(p_every), 64'd3);
        check("once.count_b0", 64'(o_cnt),   64'd1);

        // Bit 26 toggling on four consecutive cycles.
        s = sig;
        run = 0;
        for (int i = 0; i < 4; i++) begin
            s = s ^ (27'h1 << 26);
            tick(1'b0, 1'b1, 1'b0, s);
            if (e_valid[26]) run++;
        end
        check("every.run26", 64'(run),        64'd4);
        check("every.cov26", 64'(e_cov[26]), 64'd1);

        // All bits toggling at once; arming edge must stay silent.
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, ALL1);
        check("arm.valid", 64'(o_valid), 64'd0);
        tick(1'b0, 1'b1, 1'b0, '0);
        check("full.valid", 64'(o_valid), 64'h7FFFFFF);
        check("full.count", 64'(o_cnt),   64'd27);
        check("full.all",   64'(o_all),   64'd1);

        // clr coinciding with a toggle.
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 27'h3);
        check("clr.pre_cov", 64'(o_cov), 64'h3);
        tick(1'b0, 1'b1, 1'b1, 27'h1);
        check("clr.valid",   64'(o_valid), 64'h2);
        check("clr.covered", 64'(o_cov),   64'h2);
        check("clr.count",   64'(o_cnt),   64'd1);

        // Disabled window then silent re-arm.
        snap = o_cov;
        tick(1'b0, 1'b0, 1'b0, 27'h5);
        check("dis.valid0", 64'(o_valid), 64'd0);
        check("dis.cov0",   64'(o_cov),   64'(snap));
        tick(1'b0, 1'b0, 1'b0, 27'h6);
        check("dis.cov1",   64'(o_cov),   64'(snap));
        tick(1'b0, 1'b0, 1'b0, 27'h9);
        check("dis.cov2",   64'(o_cov),   64'(snap));
        tick(1'b0, 1'b1, 1'b0, 27'h10);
        check("rearm.valid", 64'(o_valid), 64'd0);
        check("rearm.cov",   64'(o_cov),   64'(snap));

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                flip = ALL1;
            end else begin
                flip = W'($urandom) & W'($urandom) & W'($urandom);
            end
            tick(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) == 0),
                 sig ^ flip);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
